mem_intf_arb_2port: RTL and testbench

MEM_INTF_ARB_2PORT -- requirements
Module: mem_intf_arb_2port

---
 rtl/mem_arb_pkg.sv | 40 ++++
 rtl/mem_intf_arb_2port_if.sv | 28 ++
 rtl/mem_arb_id_fifo.sv | 60 ++++++
 rtl/mem_intf_arb_2port.sv | 121 ++++++++++++
 tb/tb_mem_intf_arb_2port.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: message payloads, source ID,
// arbiter lock state and the default in-flight depth.
package mem_arb_pkg;

  localparam int unsigned TYPE_W   = 3;
  localparam int unsigned OPAQUE_W = 8;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LEN_W    = 2;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned TEST_W   = 2;

  localparam int unsigned DEFAULT_MAX_INFLIGHT = 4;

  // Memory request message (8-bit data flavour).
  typedef struct packed {
    logic [TYPE_W-1:0]   typ;
    logic [OPAQUE_W-1:0] opaque;
    logic [ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]    len;
    logic [DATA_W-1:0]   data;
  } mem_req_t;

  // Memory response message (8-bit data flavour).
  typedef struct packed {
    logic [TYPE_W-1:0]   typ;
    logic [OPAQUE_W-1:0] opaque;
    logic [TEST_W-1:0]   test;
    logic [LEN_W-1:0]    len;
    logic [DATA_W-1:0]   data;
  } mem_resp_t;

  // Client source ID: 0 = instruction side, 1 = data side.
  typedef logic [0:0] src_id_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/mem_intf_arb_2port_if.sv
// Memory request/response channel (MemIntf) with val/rdy handshakes.
//   client modport: drives req_val/req_msg/resp_rdy
//   server modport: drives req_rdy/resp_val/resp_msg
interface mem_intf_arb_2port_if
  import mem_arb_pkg::*;
#(
  parameter type t_req_msg  = mem_req_t,
  parameter type t_resp_msg = mem_resp_t
) ();

  logic      req_val;
  logic      req_rdy;
  t_req_msg  req_msg;
  logic      resp_val;
  logic      resp_rdy;
  t_resp_msg resp_msg;

  modport client (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport server (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// Source-ID FIFO tracking which client owns each in-flight memory request.
//   push/push_id : enqueue (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   full/empty/head/count : status decoded from registered state
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_depth = DEFAULT_MAX_INFLIGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  src_id_t                  push_id,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output src_id_t                  head,
  output logic [$clog2(p_depth):0] count
);

  localparam int unsigned PTR_W = $clog2(p_depth);
  localparam int unsigned CNT_W = PTR_W + 1;

  src_id_t          id_mem [p_depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (cnt == CNT_W'(p_depth));
  assign empty     = (cnt == '0);
  assign head      = id_mem[rd_ptr];
  assign count     = cnt;
  assign do_push_c = push & ~full;
  assign do_pop_c  = pop & ~empty;

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push_c) id_mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mem_intf_arb_2port.sv
// Two-client round-robin arbiter onto one memory port, with in-order
// response routing via a source-ID FIFO.
//   clk, rst : clock, asynchronous active-low reset
//   cli[2]   : client channels (0 = inst, 1 = data), server side
//   mem      : merged memory channel, client side
module mem_intf_arb_2port
  import mem_arb_pkg::*;
#(
  parameter type         t_req_msg      = mem_req_t,
  parameter type         t_resp_msg     = mem_resp_t,
  parameter int unsigned p_max_inflight = DEFAULT_MAX_INFLIGHT
) (
  input logic                   clk,
  input logic                   rst,
  mem_intf_arb_2port_if.server  cli [2],
  mem_intf_arb_2port_if.client  mem
);

  localparam int unsigned CNT_W = $clog2(p_max_inflight) + 1;

  arb_state_t       state;
  arb_state_t       state_nxt;
  src_id_t          ptr;
  src_id_t          lock_id;
  src_id_t          grant_c;
  src_id_t          head_c;
  logic [1:0]       req_val_c;
  logic             mem_req_val_c;
  logic             fire_c;
  logic             resp_fire_c;
  logic             full_c;
  logic             empty_c;
  logic [CNT_W-1:0] id_count;
  t_req_msg         req_msg_c;
  t_resp_msg        resp_msg_c;

  assign req_val_c = {cli[1].req_val, cli[0].req_val};

  // A locked grant wins; otherwise the preferred client unless it is idle.
  always_comb begin
    grant_c = ptr;
    if (state == ARB_LOCKED) begin
      grant_c = lock_id;
    end else if (!req_val_c[ptr]) begin
      grant_c = ~ptr;
    end
  end

  assign mem_req_val_c = req_val_c[grant_c] & ~full_c;
  assign fire_c        = mem_req_val_c & mem.req_rdy;
  assign req_msg_c     = (grant_c == src_id_t'(1)) ? cli[1].req_msg : cli[0].req_msg;

  assign mem.req_val   = mem_req_val_c;
  assign mem.req_msg   = req_msg_c;
  assign cli[0].req_rdy = (grant_c == src_id_t'(0)) & mem.req_rdy & ~full_c;
  assign cli[1].req_rdy = (grant_c == src_id_t'(1)) & mem.req_rdy & ~full_c;

  // Lock state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_OPEN;
    else      state <= state_nxt;
  end

  // Lock when a presented request is back-pressured; release on fire.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_OPEN:   if (mem_req_val_c && !mem.req_rdy) state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (fire_c) state_nxt = ARB_OPEN;
      default:    state_nxt = ARB_OPEN;
    endcase
  end

  // Priority pointer and captured lock grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      lock_id <= '0;
    end else begin
      if (fire_c) ptr <= ~grant_c;
      if (state == ARB_OPEN && state_nxt == ARB_LOCKED) lock_id <= grant_c;
    end
  end

  mem_arb_id_fifo #(
    .p_depth (p_max_inflight)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fire_c),
    .push_id (grant_c),
    .pop     (resp_fire_c),
    .full    (full_c),
    .empty   (empty_c),
    .head    (head_c),
    .count   (id_count)
  );

  // Responses go to the oldest outstanding requester; stray ones stall.
  assign resp_msg_c      = mem.resp_msg;
  assign cli[0].resp_msg = resp_msg_c;
  assign cli[1].resp_msg = resp_msg_c;
  assign cli[0].resp_val = mem.resp_val & ~empty_c & (head_c == src_id_t'(0));
  assign cli[1].resp_val = mem.resp_val & ~empty_c & (head_c == src_id_t'(1));
  assign mem.resp_rdy    = ~empty_c &
                           ((head_c == src_id_t'(1)) ? cli[1].resp_rdy : cli[0].resp_rdy);
  assign resp_fire_c     = mem.resp_val & mem.resp_rdy;

  // Line trace: grant, in-flight count, client receiving a response (or '-').
  function automatic string trace(input int trace_level);
    string s;
    s = "";
    if (trace_level > 0) begin
      s = $sformatf("g:%0d n:%0d", grant_c, id_count);
      if (resp_fire_c) s = {s, $sformatf(" r:%0d", head_c)};
      else             s = {s, " r:-"};
    end
    return s;
  endfunction

endmodule

// File: tb/tb_mem_intf_arb_2port.sv
module tb_mem_intf_arb_2port;
  import mem_arb_pkg::*;

  logic clk;
  logic rst;

  mem_intf_arb_2port_if cli_if [2] ();
  mem_intf_arb_2port_if mem_if ();

  logic [1:0] req_val, req_rdy, resp_val, resp_rdy;
  mem_req_t   req_msg  [2];
  mem_resp_t  resp_msg [2];
  logic       m_req_val, m_req_rdy, m_resp_val, m_resp_rdy;
  mem_req_t   m_req_msg;
  mem_resp_t  m_resp_msg;

  assign cli_if[0].req_val  = req_val[0];
  assign cli_if[1].req_val  = req_val[1];
  assign cli_if[0].req_msg  = req_msg[0];
  assign cli_if[1].req_msg  = req_msg[1];
  assign cli_if[0].resp_rdy = resp_rdy[0];
  assign cli_if[1].resp_rdy = resp_rdy[1];
  assign req_rdy            = {cli_if[1].req_rdy, cli_if[0].req_rdy};
  assign resp_val           = {cli_if[1].resp_val, cli_if[0].resp_val};
  assign resp_msg[0]        = cli_if[0].resp_msg;
  assign resp_msg[1]        = cli_if[1].resp_msg;

  assign m_req_val          = mem_if.req_val;
  assign m_req_msg          = mem_if.req_msg;
  assign mem_if.req_rdy     = m_req_rdy;
  assign mem_if.resp_val    = m_resp_val;
  assign mem_if.resp_msg    = m_resp_msg;
  assign m_resp_rdy         = mem_if.resp_rdy;

  mem_intf_arb_2port dut (
    .clk (clk),
    .rst (rst),
    .cli (cli_if),
    .mem (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic      cid;
    mem_resp_t msg;
  } exp_resp_t;

  mem_req_t  exp_req_q  [$];
  exp_resp_t exp_resp_q [$];
  int checks    = 0;
  int errors    = 0;
  int req_fires = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mem_req_t mk_req(input logic [7:0] op, input logic [31:0] addr);
    mem_req_t r;
    r.typ = 3'd0; r.opaque = op; r.addr = addr; r.len = 2'd0; r.data = op ^ 8'h5a;
    return r;
  endfunction

  function automatic mem_resp_t mk_resp(input logic [7:0] op);
    mem_resp_t r;
    r.typ = 3'd0; r.opaque = op; r.test = 2'd0; r.len = 2'd0; r.data = ~op;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One response beat, expected to land on client cid.
  task automatic resp_beat(input logic cid, input logic [7:0] op);
    exp_resp_t e;
    e.cid = cid;
    e.msg = mk_resp(op);
    exp_resp_q.push_back(e);
    m_resp_msg = mk_resp(op);
    m_resp_val = 1'b1;
    resp_rdy   = 2'b11;
    tick();
    m_resp_val = 1'b0;
  endtask

  // Scoreboard monitor: pops expectations whenever a handshake fires.
  always @(negedge clk) begin
    mem_req_t  er;
    exp_resp_t ers;
    if (rst) begin
      if (m_req_val && m_req_rdy) begin
        req_fires++;
        if (exp_req_q.size() == 0) begin
          check("req_unexpected", 64'(m_req_msg.addr), 64'hffffffff);
        end else begin
          er = exp_req_q.pop_front();
          check("req_msg", 64'(m_req_msg), 64'(er));
        end
      end
      if (resp_val == 2'b11) check("resp_onehot", 64'(resp_val), 64'h1);
      for (int i = 0; i < 2; i++) begin
        if (resp_val[i] && resp_rdy[i]) begin
          if (exp_resp_q.size() == 0) begin
            check("resp_unexpected", 64'(i), 64'h2);
          end else begin
            ers = exp_resp_q.pop_front();
            check("resp_client", 64'(i), 64'(ers.cid));
            check("resp_msg", 64'(resp_msg[i]), 64'(ers.msg));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_req_t c0, c1;
    rst        = 1'b0;
    req_val    = 2'b00;
    req_msg[0] = '0;
    req_msg[1] = '0;
    resp_rdy   = 2'b00;
    m_req_rdy  = 1'b0;
    m_resp_val = 1'b0;
    m_resp_msg = '0;
    #12;
    check("rst_mem_req_val", 64'(m_req_val), 64'h0);
    check("rst_cli_req_rdy", 64'(req_rdy), 64'h0);
    check("rst_cli_resp_val", 64'(resp_val), 64'h0);
    check("rst_mem_resp_rdy", 64'(m_resp_rdy), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Both clients always valid: grants alternate 0,1,0,1.
    c0 = mk_req(8'h10, 32'h10);
    c1 = mk_req(8'h20, 32'h20);
    req_msg[0] = c0;
    req_msg[1] = c1;
    exp_req_q.push_back(c0); exp_req_q.push_back(c1);
    exp_req_q.push_back(c0); exp_req_q.push_back(c1);
    req_val   = 2'b11;
    m_req_rdy = 1'b1;
    repeat (4) tick();
    req_val = 2'b00;
    check("rr_fires", 64'(req_fires), 64'd4);
    resp_beat(1'b0, 8'h01);
    resp_beat(1'b1, 8'h02);
    resp_beat(1'b0, 8'h03);
    resp_beat(1'b1, 8'h04);
    #1;
    check("drained_resp_rdy", 64'(m_resp_rdy), 64'h0);

    // Back-pressured client 1 keeps the grant after client 0 arrives.
    c1 = mk_req(8'h21, 32'h21);
    c0 = mk_req(8'h11, 32'h11);
    req_msg[0] = c0;
    req_msg[1] = c1;
    m_req_rdy  = 1'b0;
    req_val    = 2'b10;
    tick();
    check("lock_c1_val", 64'(m_req_val), 64'h1);
    check("lock_c1_msg", 64'(m_req_msg), 64'(c1));
    req_val = 2'b11;
    tick();
    check("lock_hold_msg", 64'(m_req_msg), 64'(c1));
    check("lock_hold_rdy", 64'(req_rdy), 64'h0);
    tick();
    check("lock_hold_msg2", 64'(m_req_msg), 64'(c1));
    exp_req_q.push_back(c1);
    exp_req_q.push_back(c0);
    m_req_rdy = 1'b1;
    tick();
    req_val = 2'b01;
    tick();
    req_val = 2'b00;
    resp_beat(1'b1, 8'h11);
    resp_beat(1'b0, 8'h12);

    // Five client-0 requests against depth 4: fifth waits for a response.
    for (int k = 0; k < 4; k++) begin
      req_msg[0] = mk_req(8'(8'h30 + k), 32'(32'h300 + k));
      exp_req_q.push_back(req_msg[0]);
      req_val = 2'b01;
      tick();
    end
    req_msg[0] = mk_req(8'h34, 32'h304);
    tick();
    check("full_rdy", 64'(req_rdy), 64'h0);
    check("full_val", 64'(m_req_val), 64'h0);
    tick();
    check("full_rdy2", 64'(req_rdy), 64'h0);
    exp_resp_q.push_back('{cid: 1'b0, msg: mk_resp(8'h40)});
    m_resp_msg = mk_resp(8'h40);
    m_resp_val = 1'b1;
    resp_rdy   = 2'b01;
    #1;
    check("full_pop_rdy", 64'(req_rdy), 64'h0);
    check("full_pop_resp_rdy", 64'(m_resp_rdy), 64'h1);
    exp_req_q.push_back(req_msg[0]);
    tick();
    m_resp_val = 1'b0;
    check("after_pop_rdy", 64'(req_rdy), 64'h1);
    tick();
    req_val = 2'b00;
    check("depth_fires", 64'(req_fires), 64'd11);
    for (int k = 0; k < 4; k++) resp_beat(1'b0, 8'(8'h41 + k));

    // Requests 0,1,0 with in-order responses; client 1 stalls its beat.
    c0 = mk_req(8'h50, 32'h100);
    req_msg[0] = c0; exp_req_q.push_back(c0); req_val = 2'b01; tick();
    c1 = mk_req(8'h51, 32'h200);
    req_msg[1] = c1; exp_req_q.push_back(c1); req_val = 2'b10; tick();
    c0 = mk_req(8'h52, 32'h300);
    req_msg[0] = c0; exp_req_q.push_back(c0); req_val = 2'b01; tick();
    req_val = 2'b00;
    resp_beat(1'b0, 8'h60);
    m_resp_msg = mk_resp(8'h61);
    m_resp_val = 1'b1;
    resp_rdy   = 2'b01;
    #1;
    check("route_c1_val", 64'(resp_val), 64'h2);
    check("route_c1_stall", 64'(m_resp_rdy), 64'h0);
    tick();
    check("route_c1_stall2", 64'(m_resp_rdy), 64'h0);
    resp_beat(1'b1, 8'h61);
    resp_beat(1'b0, 8'h62);

    // Stray response with nothing in flight stalls.
    m_resp_msg = mk_resp(8'h70);
    m_resp_val = 1'b1;
    resp_rdy   = 2'b11;
    tick();
    check("stray_resp_rdy", 64'(m_resp_rdy), 64'h0);
    check("stray_resp_val", 64'(resp_val), 64'h0);
    m_resp_val = 1'b0;

    // Reset with three requests in flight.
    for (int k = 0; k < 3; k++) begin
      req_msg[0] = mk_req(8'(8'h80 + k), 32'(32'h800 + k));
      exp_req_q.push_back(req_msg[0]);
      req_val = 2'b01;
      tick();
    end
    req_val = 2'b00;
    check("pre_rst_count", 64'(dut.id_count), 64'd3);
    check("pre_rst_ptr", 64'(dut.ptr), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_count", 64'(dut.id_count), 64'd0);
    check("mid_rst_ptr", 64'(dut.ptr), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    m_resp_msg = mk_resp(8'h90);
    m_resp_val = 1'b1;
    #1;
    check("late_resp_rdy", 64'(m_resp_rdy), 64'h0);
    m_resp_val = 1'b0;
    c1 = mk_req(8'h91, 32'h910);
    req_msg[1] = c1;
    exp_req_q.push_back(c1);
    req_val = 2'b10;
    tick();
    req_val = 2'b00;
    check("post_rst_count", 64'(dut.id_count), 64'd1);
    resp_beat(1'b1, 8'h92);
    tick();

    check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    check("resp_queue_empty", 64'(exp_resp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
